// File: rtl/aemb_pkg.sv
// Shared AEMB bus definitions: arbiter state encodings and watchdog width.
package aemb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_IGNT = 2'b01,
    ST_DGNT = 2'b10
  } arb_state_t;

  localparam int WDOG_W = 8;

endpackage

// File: rtl/aemb_wb_wdog.sv
// Bus watchdog: counts granted cycles without an ack, flags expiry at TMO.
import aemb_pkg::*;

module aemb_wb_wdog #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  // Expiry forces an ack, which clears the count, so it never passes TMO.
  assign expire = en && (cnt == WDOG_W'(TMO));

endmodule

// File: rtl/aemb_wb_arb.sv
// Two-master Wishbone arbiter: instruction and data ports share one slave,
// data wins ties, acks alternate grants, a watchdog terminates hung cycles.
import aemb_pkg::*;

module aemb_wb_arb #(
  parameter int ASIZ = 16,
  parameter int TMO  = 255
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [ASIZ-1:0] iwb_adr_i,
  input  logic            iwb_stb_i,
  output logic [31:0]     iwb_dat_o,
  output logic            iwb_ack_o,
  input  logic [ASIZ-1:0] dwb_adr_i,
  input  logic            dwb_stb_i,
  input  logic            dwb_we_i,
  input  logic [31:0]     dwb_dat_i,
  output logic [31:0]     dwb_dat_o,
  output logic            dwb_ack_o,
  output logic [ASIZ-1:0] mem_adr_o,
  output logic            mem_stb_o,
  output logic            mem_we_o,
  output logic [31:0]     mem_dat_o,
  input  logic [31:0]     mem_dat_i,
  input  logic            mem_ack_i,
  output logic [1:0]      gnt_o,
  output logic            bus_err_o
);

  arb_state_t state, state_nxt;

  logic igrant, dgrant;
  logic gstb;
  logic slv_ack;
  logic expire;
  logic wd_ack;
  logic any_ack;

  assign igrant  = (state == ST_IGNT);
  assign dgrant  = (state == ST_DGNT);
  assign gstb    = (igrant & iwb_stb_i) | (dgrant & dwb_stb_i);
  assign slv_ack = gstb & mem_ack_i;
  assign wd_ack  = expire & ~mem_ack_i;
  assign any_ack = slv_ack | expire;

  // Counter restarts at every grant entry: cleared while idle, on every ack
  // and when the granted master drops its strobe.
  aemb_wb_wdog #(
    .TMO(TMO)
  ) u_wdog (
    .clk    (sys_clk_i),
    .rst    (sys_rst_i),
    .clr    (~gstb | any_ack),
    .en     (gstb),
    .expire (expire)
  );

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (dwb_stb_i)
          state_nxt = ST_DGNT;
        else if (iwb_stb_i)
          state_nxt = ST_IGNT;
      end
      ST_IGNT: begin
        if (!iwb_stb_i)
          state_nxt = ST_IDLE;
        else if (any_ack)
          state_nxt = dwb_stb_i ? ST_DGNT : ST_IDLE;
      end
      ST_DGNT: begin
        if (!dwb_stb_i)
          state_nxt = ST_IDLE;
        else if (any_ack)
          state_nxt = iwb_stb_i ? ST_IGNT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_stb_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = iwb_adr_i;
    mem_dat_o = dwb_dat_i;
    iwb_ack_o = 1'b0;
    dwb_ack_o = 1'b0;
    iwb_dat_o = mem_dat_i;
    dwb_dat_o = mem_dat_i;
    bus_err_o = wd_ack;
    unique case (state)
      ST_IGNT: begin
        mem_stb_o = iwb_stb_i;
        iwb_ack_o = any_ack;
        if (wd_ack)
          iwb_dat_o = 32'h0;
      end
      ST_DGNT: begin
        mem_stb_o = dwb_stb_i;
        mem_we_o  = dwb_we_i;
        mem_adr_o = dwb_adr_i;
        dwb_ack_o = any_ack;
        if (wd_ack)
          dwb_dat_o = 32'h0;
      end
      default: ;
    endcase
  end

  assign gnt_o = state;

endmodule

// File: tb/tb_aemb_wb_arb.sv
// Directed bench for aemb_wb_arb (ASIZ=16, TMO=4).
module tb_aemb_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iwb_adr;
  logic        iwb_stb;
  logic [31:0] iwb_dat;
  logic        iwb_ack;
  logic [15:0] dwb_adr;
  logic        dwb_stb;
  logic        dwb_we;
  logic [31:0] dwb_wdat;
  logic [31:0] dwb_dat;
  logic        dwb_ack;
  logic [15:0] mem_adr;
  logic        mem_stb;
  logic        mem_we;
  logic [31:0] mem_wdat;
  logic [31:0] mem_rdat;
  logic        mem_ack;
  logic [1:0]  gnt;
  logic        bus_err;

  int checks = 0;
  int failures = 0;
  int iacks, dacks;

  always #5 clk = ~clk;

  aemb_wb_arb #(.ASIZ(16), .TMO(4)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .iwb_adr_i (iwb_adr),
    .iwb_stb_i (iwb_stb),
    .iwb_dat_o (iwb_dat),
    .iwb_ack_o (iwb_ack),
    .dwb_adr_i (dwb_adr),
    .dwb_stb_i (dwb_stb),
    .dwb_we_i  (dwb_we),
    .dwb_dat_i (dwb_wdat),
    .dwb_dat_o (dwb_dat),
    .dwb_ack_o (dwb_ack),
    .mem_adr_o (mem_adr),
    .mem_stb_o (mem_stb),
    .mem_we_o  (mem_we),
    .mem_dat_o (mem_wdat),
    .mem_dat_i (mem_rdat),
    .mem_ack_i (mem_ack),
    .gnt_o     (gnt),
    .bus_err_o (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    iwb_adr = '0; iwb_stb = 1'b0;
    dwb_adr = '0; dwb_stb = 1'b0; dwb_we = 1'b0; dwb_wdat = '0;
    mem_rdat = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_stb", mem_stb, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_iack", iwb_ack, 0);
    chk("rst_dack", dwb_ack, 0);
    chk("rst_err", bus_err, 0);

    // Single fetch, slave acks one cycle after mem_stb
    iwb_adr = 16'h0040; iwb_stb = 1'b1;
    #1 chk("f_idle_stb", mem_stb, 0);
    tick();
    chk("f_gnt", gnt, 2'b01);
    chk("f_stb", mem_stb, 1);
    chk("f_adr", mem_adr, 16'h0040);
    chk("f_we", mem_we, 0);
    chk("f_noack", iwb_ack, 0);
    tick();
    mem_ack = 1'b1; mem_rdat = 32'hB8000000;
    #1;
    chk("f_iack", iwb_ack, 1);
    chk("f_idat", iwb_dat, 32'hB8000000);
    chk("f_dack", dwb_ack, 0);
    tick();
    mem_ack = 1'b0; iwb_stb = 1'b0;
    #1 chk("f_back_idle", gnt, 2'b00);

    // Tie: data write first, then the fetch with no IDLE gap
    iwb_adr = 16'h0100; iwb_stb = 1'b1;
    dwb_adr = 16'h8888; dwb_stb = 1'b1; dwb_we = 1'b1; dwb_wdat = 32'h7A55ED00;
    tick();
    chk("t_gnt_d", gnt, 2'b10);
    chk("t_adr_d", mem_adr, 16'h8888);
    chk("t_we_d", mem_we, 1);
    chk("t_dat_d", mem_wdat, 32'h7A55ED00);
    chk("t_stb_d", mem_stb, 1);
    mem_ack = 1'b1;
    #1;
    chk("t_dack", dwb_ack, 1);
    chk("t_iack0", iwb_ack, 0);
    tick();
    dwb_stb = 1'b0; dwb_we = 1'b0;
    #1;
    chk("t_gnt_i", gnt, 2'b01);
    chk("t_adr_i", mem_adr, 16'h0100);
    chk("t_we_i", mem_we, 0);
    chk("t_iack", iwb_ack, 1);
    chk("t_dack0", dwb_ack, 0);
    tick();
    mem_ack = 1'b0; iwb_stb = 1'b0;
    #1 chk("t_idle", gnt, 2'b00);

    // Both masters held for 8 acks: grants alternate D,I,D,I,...
    iwb_stb = 1'b1; dwb_stb = 1'b1; dwb_we = 1'b0;
    iacks = 0; dacks = 0;
    tick();
    mem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("alt_gnt%0d", k), gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("alt_stb%0d", k), mem_stb, 1);
      if (iwb_ack) iacks++;
      if (dwb_ack) dacks++;
      tick();
    end
    mem_ack = 1'b0; iwb_stb = 1'b0; dwb_stb = 1'b0;
    chk("alt_iacks", iacks, 4);
    chk("alt_dacks", dacks, 4);
    tick();
    chk("alt_idle", gnt, 2'b00);

    // Watchdog: data cycle never acked, expiry on the 5th granted cycle
    dwb_stb = 1'b1; dwb_adr = 16'h1234; mem_rdat = 32'hDEADBEEF;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("wd_noack%0d", c), dwb_ack, 0);
      chk($sformatf("wd_noerr%0d", c), bus_err, 0);
      tick();
    end
    chk("wd_gnt", gnt, 2'b10);
    chk("wd_dack", dwb_ack, 1);
    chk("wd_err", bus_err, 1);
    chk("wd_ddat", dwb_dat, 32'h0);
    chk("wd_idat", iwb_dat, 32'hDEADBEEF);
    chk("wd_stb", mem_stb, 1);
    tick();
    dwb_stb = 1'b0;
    #1;
    chk("wd_idle", gnt, 2'b00);
    chk("wd_err_end", bus_err, 0);

    // Slave ack coincident with expiry: normal ack, no bus error
    dwb_stb = 1'b1;
    tick();
    repeat (4) tick();
    mem_ack = 1'b1;
    #1;
    chk("co_dack", dwb_ack, 1);
    chk("co_err", bus_err, 0);
    chk("co_ddat", dwb_dat, 32'hDEADBEEF);
    tick();
    mem_ack = 1'b0; dwb_stb = 1'b0;
    #1 chk("co_idle", gnt, 2'b00);

    // Reset mid-DGNT just before the slave ack
    dwb_stb = 1'b1;
    tick();
    chk("r_gnt", gnt, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b1;
    #1;
    chk("r_gnt0", gnt, 2'b00);
    chk("r_stb0", mem_stb, 0);
    chk("r_we0", mem_we, 0);
    chk("r_dack0", dwb_ack, 0);
    chk("r_iack0", iwb_ack, 0);
    chk("r_err0", bus_err, 0);
    mem_ack = 1'b0;
    tick();
    chk("r_rearb", gnt, 2'b10);
    dwb_stb = 1'b0;
    tick();
    chk("r_idle", gnt, 2'b00);

    // Granted fetch dropped without ack, then the watchdog restarts from 0
    iwb_stb = 1'b1;
    tick(); tick(); tick();
    iwb_stb = 1'b0;
    #1 chk("d_noack", iwb_ack, 0);
    tick();
    chk("d_idle", gnt, 2'b00);
    chk("d_noack2", iwb_ack, 0);
    iwb_stb = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("d_wd_noerr%0d", c), bus_err, 0);
      tick();
    end
    chk("d_wd_err", bus_err, 1);
    chk("d_wd_iack", iwb_ack, 1);
    chk("d_wd_idat", iwb_dat, 32'h0);
    tick();
    iwb_stb = 1'b0;
    #1 chk("d_end_idle", gnt, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aemb_wb_arb.md
AEMB_WB_ARB -- requirements
Module: aemb_wb_arb

Interface
REQ-001 SHALL have parameter ASIZ, default 16, the width in bits of the bus byte address.
REQ-002 SHALL have parameter TMO, default 255, the watchdog limit in cycles (range 1..255) for a granted cycle that gets no slave ack.
REQ-003 sys_clk_i  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 sys_rst_i  in  1  reset, synchronous and active-high.
REQ-005 iwb_adr_i  in  ASIZ  instruction-fetch address from the core.
REQ-006 iwb_stb_i  in  1  instruction-fetch request.
REQ-007 iwb_dat_o  out  32  instruction read data.
REQ-008 iwb_ack_o  out  1  instruction-fetch completion.
REQ-009 dwb_adr_i  in  ASIZ  data address.
REQ-010 dwb_stb_i  in  1  data request.
REQ-011 dwb_we_i  in  1  data write enable.
REQ-012 dwb_dat_i  in  32  data write value.
REQ-013 dwb_dat_o  out  32  data read value.
REQ-014 dwb_ack_o  out  1  data completion.
REQ-015 mem_adr_o  out  ASIZ, mem_stb_o  out  1, mem_we_o  out  1, mem_dat_o  out  32: the shared slave port outputs.
REQ-016 mem_dat_i  in  32, mem_ack_i  in  1: the shared slave port inputs.
REQ-017 gnt_o  out  2  current grant: 00 idle, 01 instruction, 10 data.
REQ-018 bus_err_o  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, IGNT, DGNT.
REQ-020 In IDLE with dwb_stb_i=1, SHALL move to DGNT on the next edge, even if iwb_stb_i=1 (data has priority on a tie).
REQ-021 In IDLE with only iwb_stb_i=1, SHALL move to IGNT on the next edge; with neither request, SHALL stay in IDLE.
REQ-022 Arbitration latency SHALL be exactly one cycle from IDLE; mem_stb_o SHALL never assert in IDLE.
REQ-023 In IGNT, mem_stb_o SHALL equal iwb_stb_i, mem_adr_o SHALL equal iwb_adr_i, and mem_we_o SHALL be 0.
REQ-024 In DGNT, mem_stb_o SHALL equal dwb_stb_i; mem_adr_o, mem_we_o and mem_dat_o SHALL equal the dwb inputs.
REQ-025 mem_ack_i SHALL pass combinationally to the granted master's ack only; the ungranted master's ack SHALL be 0.
REQ-026 mem_ack_i outside IGNT/DGNT SHALL be ignored.
REQ-027 mem_dat_i SHALL drive both iwb_dat_o and dwb_dat_o, except on a watchdog ack, when the granted master's data SHALL be 32'h0.
REQ-028 On the ack cycle, the next state SHALL be the other master's grant if that master's stb is 1, else IDLE.
REQ-029 Because of REQ-028, continuous requests from both masters SHALL alternate grants, with no return to IDLE.
REQ-030 If the granted master drops stb without an ack, SHALL return to IDLE next cycle and issue no ack.
REQ-031 An 8-bit watchdog counter SHALL clear on every grant entry and increment each granted cycle with no ack.
REQ-032 When the counter reaches TMO, in that same cycle:
  - ack the granted master;
  - pulse bus_err_o for 1 cycle;
  - keep mem_stb_o asserted;
  - choose the next state per REQ-028.
REQ-033 mem_ack_i and watchdog expiry in the same cycle SHALL be treated as a normal ack, with bus_err_o=0.
REQ-034 gnt_o SHALL reflect the registered FSM state.

Reset
REQ-035 While sys_rst_i=1 at an edge, SHALL set state IDLE and the counter to 0, aborting any granted cycle without ack.
REQ-036 After reset: mem_stb_o=0, mem_we_o=0, iwb_ack_o=0, dwb_ack_o=0, bus_err_o=0, gnt_o=00.
REQ-037 Data and address outputs SHALL have no reset requirement.

Structure
REQ-038 State encodings (IDLE=2'b00, IGNT=2'b01, DGNT=2'b10) and the 8-bit watchdog width SHALL live in the shared aemb package, not in this module.
REQ-039 The watchdog SHALL be a sub-module aemb_wb_wdog (clear, enable, expire out).
REQ-040 All else SHALL be flat in aemb_wb_arb.

Verification
REQ-041 Single fetch: iwb_stb_i=1, adr 16'h0040, slave acks 1 cycle after mem_stb_o with 32'hB8000000 -> gnt_o=01 at cycle+1, iwb_ack_o with that data, dwb_ack_o=0.
REQ-042 Tie: iwb_stb_i and dwb_stb_i rise together, dwb write adr 16'h8888, data 32'h7A55ED00 -> slave sees that write first, then the fetch with no IDLE gap, mem_we_o=0 on the fetch.
REQ-043 Both held for 8 acks -> grants alternate D,I,D,I,...; each master gets exactly 4 acks.
REQ-044 DGNT, slave never acks, TMO=4 -> dwb_ack_o and bus_err_o pulse on the 5th granted cycle, dwb_dat_o=0, then IDLE.
REQ-045 sys_rst_i asserted mid-DGNT just before the slave ack -> no dwb_ack_o, all outputs at reset values next cycle, a fresh request arbitrates normally.
REQ-046 Granted iwb_stb_i dropped without ack -> IDLE next cycle, no ack, counter cleared.
